// File: rtl/ascii_decimal_parser.sv
// ascii_decimal_parser: accumulate ASCII decimal digits from a UART byte stream into a WIDTH-bit value, pulse value_valid on each line terminator
//   clk          system clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   rx_data      received ASCII byte, sampled when rx_new_data=1
//   rx_new_data  single-cycle strobe qualifying rx_data
//   value        last parsed result, held until the next completed line
//   value_valid  one-cycle pulse when value/value_error update
//   value_error  error status of the line just completed
//   digit_count  digits accepted so far in the current line
//   Optional: define ASCII_DECIMAL_PARSER_NEG_EN to accept a leading '-' and return two's complement results.
module ascii_decimal_parser #(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_new_data,
  output logic [WIDTH-1:0] value,
  output logic             value_valid,
  output logic             value_error,
  output logic [3:0]       digit_count
);
  typedef enum logic [1:0] {IDLE, ACCUM, DISCARD} state_t;
  state_t           state_q;
  logic [WIDTH+3:0] acc_q, acc_d;
  logic [3:0]       cnt_q;
  logic             err_q;
  logic [WIDTH-1:0] value_q;
  logic             valid_q, verr_q;
  logic             is_digit, is_term, ovf, cnt_full, fin_err;
  logic [WIDTH-1:0] fin_val;
`ifdef ASCII_DECIMAL_PARSER_NEG_EN
  localparam logic [WIDTH+3:0] NEG_LIM = (WIDTH+4)'(1) << (WIDTH-1);
  logic neg_q, is_minus;
`endif
  always_comb begin
    is_digit = rx_data >= 8'h30 && rx_data <= 8'h39;
    is_term  = rx_data == 8'h0A || rx_data == 8'h0D;
    // acc*10 + digit; the 4 extra bits make overflow past 2^WIDTH-1 visible
    acc_d    = (acc_q << 3) + (acc_q << 1) + {{WIDTH{1'b0}}, rx_data[3:0]};
    ovf      = |acc_d[WIDTH+3:WIDTH];
    cnt_full = cnt_q == 4'(MAX_DIGITS);
`ifdef ASCII_DECIMAL_PARSER_NEG_EN
    is_minus = rx_data == 8'h2D;
    // a bare "-" or a magnitude beyond 2^(WIDTH-1) cannot be represented
    fin_err  = err_q | (neg_q & (cnt_q == 4'd0 || acc_q > NEG_LIM));
    fin_val  = fin_err ? '0 : neg_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
`else
    fin_err  = err_q;
    fin_val  = fin_err ? '0 : acc_q[WIDTH-1:0];
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      value_q <= '0;
      valid_q <= 1'b0;
      verr_q  <= 1'b0;
`ifdef ASCII_DECIMAL_PARSER_NEG_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (rx_new_data) begin
        if (is_term && state_q != IDLE) begin
          valid_q <= 1'b1;
          verr_q  <= fin_err;
          value_q <= fin_val;
          acc_q   <= '0;
          cnt_q   <= '0;
          err_q   <= 1'b0;
          state_q <= IDLE;
`ifdef ASCII_DECIMAL_PARSER_NEG_EN
          neg_q   <= 1'b0;
`endif
        end else if (state_q == IDLE) begin
          if (is_digit) begin
            acc_q   <= {{WIDTH{1'b0}}, rx_data[3:0]};
            cnt_q   <= 4'd1;
            state_q <= ACCUM;
`ifdef ASCII_DECIMAL_PARSER_NEG_EN
          end else if (is_minus) begin
            neg_q   <= 1'b1;
            state_q <= ACCUM;
`endif
          end else if (!is_term) begin
            err_q   <= 1'b1;
            state_q <= DISCARD;
          end
        end else if (state_q == ACCUM) begin
          if (!is_digit || cnt_full || ovf) begin
            err_q   <= 1'b1;
            state_q <= DISCARD;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 4'd1;
          end
        end
      end
    end
  end
  assign value       = value_q;
  assign value_valid = valid_q;
  assign value_error = verr_q;
  assign digit_count = state_q == IDLE ? 4'd0 : cnt_q;
endmodule

// File: tb/tb_ascii_decimal_parser.sv
// tb_ascii_decimal_parser: scoreboard bench driving directed ASCII lines and checking each value_valid pulse
module tb_ascii_decimal_parser;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_new_data = 1'b0;
  logic [31:0] value;
  logic        value_valid, value_error;
  logic [3:0]  digit_count;
  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];

  ascii_decimal_parser #(.WIDTH(32), .MAX_DIGITS(10)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_new_data(rx_new_data),
    .value(value), .value_valid(value_valid), .value_error(value_error),
    .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (value_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got value=0x%0h err=%0b expected no pulse", value, value_error);
      end else chk("line_result", {value_error, value}, exp_q.pop_front());
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_new_data = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_new_data = 1'b0;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic line(input string s, input logic [31:0] v, input logic e);
    exp_q.push_back({e, v});
    send_str(s);
    idle(3);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, 33'(exp_q.size()), 33'd0);
  endtask

  initial begin
    #12;
    chk("reset_value", {value_valid, value}, 33'd0);
    chk("reset_err_cnt", 33'({value_error, digit_count}), 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_str("1234");
    idle(1);
    #1 chk("count_1234", 33'(digit_count), 33'd4);
    exp_q.push_back({1'b0, 32'h0000_04D2});
    send("\n");
    idle(3);
    #1 chk("count_after_line", 33'(digit_count), 33'd0);
    send_str("4294967295");
    idle(1);
    #1 chk("count_10", 33'(digit_count), 33'd10);
    line("\r\n", 32'hFFFF_FFFF, 1'b0);
    line("4294967296\n", 32'h0, 1'b1);
    line("00000000012\n", 32'h0, 1'b1);
    line("0000000012\n", 32'd12, 1'b0);
    line("12a4\n", 32'h0, 1'b1);
    line("7\n", 32'd7, 1'b0);
    line("\r\n\n", 32'd0, 1'b0);
    exp_q.pop_back();
    line("x\r", 32'h0, 1'b1);
    line("0\n", 32'h0, 1'b0);
`ifdef ASCII_DECIMAL_PARSER_NEG_EN
    line("-1\n", 32'hFFFF_FFFF, 1'b0);
    line("-2147483649\n", 32'h0, 1'b1);
    line("-2147483648\n", 32'h8000_0000, 1'b0);
    line("-\n", 32'h0, 1'b1);
    line("1-\n", 32'h0, 1'b1);
`else
    line("-1\n", 32'h0, 1'b1);
`endif
    drain("lines_drained");
    send_str("99");
    idle(1);
    #1 chk("count_99", 33'(digit_count), 33'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midreset_value", {value_valid, value}, 33'd0);
    chk("midreset_cnt", 33'({value_error, digit_count}), 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    line("5\n", 32'd5, 1'b0);
    drain("final_drained");
    idle(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
